fp_compare_param: RTL

Parametrised IEEE-754 floating-point comparator for the FPU datapath. Built as the successor to the fixed half-precision comparator. It accepts two operands of configurable exponent and mantissa width over stb/ack handshakes and returns one of four results: equal, greater, less or unordered. It also raises an IEEE invalid flag, with quiet or signalling predicate semantics selected per operation. It sits beside the add/mul units and feeds the branch/select logic.

---
 rtl/fp_compare_param.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/fp_compare_param.sv
// Parametrised IEEE-754 comparator with stb/ack operand and result handshakes.
// Define FP_CMP_TOTAL_ORDER_EN for totalOrder semantics (-0 < +0, NaNs ordered).
module fp_compare_param #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10,
    localparam int W = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] input_a,
    input  logic         input_a_stb,
    output logic         input_a_ack,
    input  logic [W-1:0] input_b,
    input  logic         input_b_stb,
    output logic         input_b_ack,
    input  logic         mode_sig,
    output logic         output_z_stb,
    input  logic         output_z_ack,
    output logic [1:0]   cmp_out,
    output logic         invalid
);

    // state    | meaning
    // GET_A    | waiting for operand A
    // GET_B    | waiting for operand B and mode_sig
    // CLASSIFY | register NaN / sNaN / zero flags
    // COMPARE  | evaluate ordering rules, load result
    // PUT_Z    | result valid until consumed
    typedef enum logic [2:0] {
        GET_A    = 3'd0,
        GET_B    = 3'd1,
        CLASSIFY = 3'd2,
        COMPARE  = 3'd3,
        PUT_Z    = 3'd4
    } state_t;

    state_t state, next_state;

    logic [W-1:0] a_reg, b_reg;
    logic         sig_reg;
    logic         a_nan, a_snan, a_zero;
    logic         b_nan, b_snan, b_zero;
    logic         a_xfer, b_xfer, z_xfer;
    logic [1:0]   res_cmp, ord_cmp;
    logic         res_inv;

    assign a_xfer = (state == GET_A) && input_a_stb && input_a_ack;
    assign b_xfer = (state == GET_B) && input_b_stb && input_b_ack;
    assign z_xfer = (state == PUT_Z) && output_z_stb && output_z_ack;

    always_ff @(posedge clk) begin
        if (rst) state <= GET_A;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            GET_A:    if (a_xfer) next_state = GET_B;
            GET_B:    if (b_xfer) next_state = CLASSIFY;
            CLASSIFY: next_state = COMPARE;
            COMPARE:  next_state = PUT_Z;
            PUT_Z:    if (z_xfer) next_state = GET_A;
            default:  next_state = GET_A;
        endcase
    end

    // Magnitude ordering of {exp,man} with sign; also serves totalOrder.
    logic         a_sign, b_sign;
    logic [W-2:0] a_mag, b_mag;
    assign a_sign = a_reg[W-1];
    assign b_sign = b_reg[W-1];
    assign a_mag  = a_reg[W-2:0];
    assign b_mag  = b_reg[W-2:0];

    always_comb begin
        ord_cmp = 2'b00;
        if (a_sign != b_sign)
            ord_cmp = a_sign ? 2'b10 : 2'b01;
        else if (a_mag == b_mag)
            ord_cmp = 2'b00;
        else if ((a_mag > b_mag) ^ a_sign)
            ord_cmp = 2'b01;
        else
            ord_cmp = 2'b10;
    end

    always_comb begin
        res_inv = (a_nan || b_nan) && (sig_reg || a_snan || b_snan);
`ifdef FP_CMP_TOTAL_ORDER_EN
        res_cmp = ord_cmp;
`else
        if (a_nan || b_nan)
            res_cmp = 2'b11;
        else if (a_zero && b_zero)
            res_cmp = 2'b00;
        else
            res_cmp = ord_cmp;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            input_a_ack  <= 1'b0;
            input_b_ack  <= 1'b0;
            output_z_stb <= 1'b0;
            cmp_out      <= 2'b00;
            invalid      <= 1'b0;
            a_reg        <= '0;
            b_reg        <= '0;
            sig_reg      <= 1'b0;
            a_nan        <= 1'b0;
            a_snan       <= 1'b0;
            a_zero       <= 1'b0;
            b_nan        <= 1'b0;
            b_snan       <= 1'b0;
            b_zero       <= 1'b0;
        end else begin
            input_a_ack  <= (next_state == GET_A);
            input_b_ack  <= (state == GET_B) && !b_xfer;
            output_z_stb <= (next_state == PUT_Z);
            if (a_xfer) a_reg <= input_a;
            if (b_xfer) begin
                b_reg   <= input_b;
                sig_reg <= mode_sig;
            end
            if (state == CLASSIFY) begin
                a_nan  <= (&a_reg[W-2:MAN_W]) && (|a_reg[MAN_W-1:0]);
                a_snan <= (&a_reg[W-2:MAN_W]) && (|a_reg[MAN_W-1:0]) && !a_reg[MAN_W-1];
                a_zero <= ~|a_reg[W-2:0];
                b_nan  <= (&b_reg[W-2:MAN_W]) && (|b_reg[MAN_W-1:0]);
                b_snan <= (&b_reg[W-2:MAN_W]) && (|b_reg[MAN_W-1:0]) && !b_reg[MAN_W-1];
                b_zero <= ~|b_reg[W-2:0];
            end
            if (state == COMPARE) begin
                cmp_out <= res_cmp;
                invalid <= res_inv;
            end
        end
    end

endmodule
